// File: rtl/pkt_buf_pkg.sv
// Shared types and constants for the packet buffer controller.
package pkt_buf_pkg;

  localparam int unsigned SKID_DEPTH = 2;

  localparam int unsigned DEF_ADDR_WIDTH = 12;
  localparam int unsigned DEF_LEN_WIDTH  = 8;

  // Descriptor layout in the default configuration; the FIFO stores {sop, len} in this order.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] sop;
    logic [DEF_LEN_WIDTH-1:0]  len;
  } desc_t;

  typedef enum logic [1:0] {WIdle, WPkt, WDrop} w_state_e;
  typedef enum logic [1:0] {RIdle, RFirst, RBody} r_state_e;

endpackage

// File: rtl/pkt_desc_fifo.sv
// Synchronous first-word-fall-through descriptor FIFO with async reset pointers.
module pkt_desc_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (PtrW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/pkt_buf_ctrl.sv
// Packet buffer sequencer: stores ingress packets via the free-list manager and
// replays them from descriptors onto the egress stream.
module pkt_buf_ctrl
  import pkt_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 256,
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned LEN_WIDTH     = 8,
  parameter int unsigned MAX_PKT_WORDS = 48,
  parameter int unsigned DESC_DEPTH    = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  am_wr_en,
  output logic                  am_rd_en,
  output logic                  am_rd_first_word_en,
  output logic [ADDR_WIDTH-1:0] am_rd_pkt_sop_addr,
  input  logic [ADDR_WIDTH-1:0] am_fl_head,
  input  logic [ADDR_WIDTH-1:0] am_fl_tail_next,
  input  logic                  am_almost_full,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_waddr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [ADDR_WIDTH-1:0] dmem_raddr,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [31:0]           stat_pkt_cnt,
  output logic [31:0]           stat_drop_cnt,
  output logic [31:0]           stat_trunc_cnt
);

  localparam int unsigned DescW = ADDR_WIDTH + LEN_WIDTH;
  localparam logic [LEN_WIDTH-1:0] MaxLen = LEN_WIDTH'(MAX_PKT_WORDS);
  localparam logic [LEN_WIDTH-1:0] OneLen = LEN_WIDTH'(1);

  // ---------------- Write side ----------------
  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] sop_q, sop_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  trunc_q, trunc_d;
  logic                  tready_q;
  logic                  w_acc, wr, push, push_trunc, drop_inc;
  logic [ADDR_WIDTH-1:0] push_sop;
  logic [LEN_WIDTH-1:0]  push_len;
  logic                  desc_full, desc_empty, desc_pop;
  logic [DescW-1:0]      desc_rdata;
  logic [31:0]           pkt_cnt_q, drop_cnt_q, trunc_cnt_q;

  assign s_axis_tready = tready_q;
  assign w_acc         = s_axis_tvalid & tready_q;
  assign am_wr_en      = wr;
  assign dmem_we       = wr;
  assign dmem_waddr    = wr ? am_fl_head : '0;
  assign dmem_wdata    = wr ? s_axis_tdata : '0;

  always_comb begin
    w_state_d  = w_state_q;
    sop_d      = sop_q;
    len_d      = len_q;
    trunc_d    = trunc_q;
    wr         = 1'b0;
    push       = 1'b0;
    push_sop   = '0;
    push_len   = '0;
    push_trunc = 1'b0;
    drop_inc   = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (w_acc) begin
          if (am_almost_full || desc_full) begin
            if (s_axis_tlast) drop_inc = 1'b1;
            else              w_state_d = WDrop;
          end else begin
            wr      = 1'b1;
            sop_d   = am_fl_head;
            len_d   = OneLen;
            trunc_d = 1'b0;
            if (s_axis_tlast) begin
              push     = 1'b1;
              push_sop = am_fl_head;
              push_len = OneLen;
            end else begin
              w_state_d = WPkt;
            end
          end
        end
      end
      WPkt: begin
        if (w_acc) begin
          // Beats past the length limit are swallowed to keep the stream aligned.
          if (len_q < MaxLen) begin
            wr    = 1'b1;
            len_d = len_q + OneLen;
          end else begin
            trunc_d = 1'b1;
          end
          if (s_axis_tlast) begin
            push       = 1'b1;
            push_sop   = sop_q;
            push_len   = len_d;
            push_trunc = trunc_d;
            w_state_d  = WIdle;
          end
        end
      end
      WDrop: begin
        if (w_acc && s_axis_tlast) begin
          drop_inc  = 1'b1;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q   <= WIdle;
      sop_q       <= '0;
      len_q       <= '0;
      trunc_q     <= 1'b0;
      tready_q    <= 1'b0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      trunc_cnt_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      sop_q     <= sop_d;
      len_q     <= len_d;
      trunc_q   <= trunc_d;
      tready_q  <= 1'b1;
      if (push)              pkt_cnt_q   <= pkt_cnt_q + 32'd1;
      if (drop_inc)          drop_cnt_q  <= drop_cnt_q + 32'd1;
      if (push & push_trunc) trunc_cnt_q <= trunc_cnt_q + 32'd1;
    end
  end

  assign stat_pkt_cnt   = pkt_cnt_q;
  assign stat_drop_cnt  = drop_cnt_q;
  assign stat_trunc_cnt = trunc_cnt_q;

  pkt_desc_fifo #(
    .WIDTH (DescW),
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata ({push_sop, push_len}),
    .pop   (desc_pop),
    .rdata (desc_rdata),
    .full  (desc_full),
    .empty (desc_empty)
  );

  // ---------------- Read side ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] rd_sop_q, rd_sop_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  inflight_q, inflight_last_q;
  logic                  issue, issue_last, credit;
  logic [2:0]            credit_sum;

  logic [SKID_DEPTH-1:0][DATA_WIDTH-1:0] skid_data_q;
  logic [SKID_DEPTH-1:0]                 skid_last_q;
  logic                                  skid_wp_q, skid_rp_q;
  logic [1:0]                            skid_occ_q;
  logic                                  skid_pop;

  assign m_axis_tvalid = (skid_occ_q != 2'd0);
  assign m_axis_tdata  = skid_data_q[skid_rp_q];
  assign m_axis_tlast  = m_axis_tvalid & skid_last_q[skid_rp_q];
  assign skid_pop      = m_axis_tvalid & m_axis_tready;

  // A slot must be free for the word issued now, counting the one still in the RAM pipe.
  assign credit_sum = {1'b0, skid_occ_q} + 3'(inflight_q) - 3'(skid_pop);
  assign credit     = (credit_sum < 3'(SKID_DEPTH));

  assign am_rd_pkt_sop_addr = rd_sop_q;

  always_comb begin
    r_state_d           = r_state_q;
    rd_sop_d            = rd_sop_q;
    rem_d               = rem_q;
    desc_pop            = 1'b0;
    issue               = 1'b0;
    issue_last          = 1'b0;
    am_rd_en            = 1'b0;
    am_rd_first_word_en = 1'b0;
    dmem_raddr          = '0;
    unique case (r_state_q)
      RIdle: begin
        if (!desc_empty && credit) begin
          desc_pop  = 1'b1;
          rd_sop_d  = desc_rdata[DescW-1 -: ADDR_WIDTH];
          rem_d     = desc_rdata[LEN_WIDTH-1:0];
          r_state_d = RFirst;
        end
      end
      RFirst: begin
        if (credit) begin
          issue               = 1'b1;
          issue_last          = (rem_q == OneLen);
          am_rd_en            = 1'b1;
          am_rd_first_word_en = 1'b1;
          dmem_raddr          = rd_sop_q;
          rem_d               = rem_q - OneLen;
          r_state_d           = issue_last ? RIdle : RBody;
        end
      end
      RBody: begin
        if (credit) begin
          issue      = 1'b1;
          issue_last = (rem_q == OneLen);
          am_rd_en   = 1'b1;
          dmem_raddr = am_fl_tail_next;
          rem_d      = rem_q - OneLen;
          if (issue_last) r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q       <= RIdle;
      rd_sop_q        <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      r_state_q       <= r_state_d;
      rd_sop_q        <= rd_sop_d;
      rem_q           <= rem_d;
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skid_data_q <= '0;
      skid_last_q <= '0;
      skid_wp_q   <= 1'b0;
      skid_rp_q   <= 1'b0;
      skid_occ_q  <= 2'd0;
    end else begin
      if (inflight_q) begin
        skid_data_q[skid_wp_q] <= dmem_rdata;
        skid_last_q[skid_wp_q] <= inflight_last_q;
        skid_wp_q              <= ~skid_wp_q;
      end
      if (skid_pop) skid_rp_q <= ~skid_rp_q;
      skid_occ_q <= skid_occ_q + 2'(inflight_q) - 2'(skid_pop);
    end
  end

endmodule
